ehgu_hamming_secded_dec: RTL and testbench

EHGU_HAMMING_SECDED_DEC -- requirements
Module: ehgu_hamming_secded_dec

---
 rtl/ehgu_hamming_secded_pkg.sv | 29 ++
 rtl/ehgu_hamming_syndrome.sv | 29 ++
 rtl/ehgu_hamming_secded_dec.sv | 145 ++++++++++++++
 tb/tb_ehgu_hamming_secded_dec.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ehgu_hamming_secded_pkg.sv
// Shared constants and types for the Hamming SECDED decoder.
// Default geometry is Hamming(7,4) plus an overall even-parity bit.
package ehgu_hamming_secded_pkg;

    localparam int HAM_N = 7;
    localparam int HAM_K = 4;
    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        ERR_CLEAN = 2'd0,
        ERR_SEC   = 2'd1,
        ERR_DED   = 2'd2
    } err_class_t;

    // Bit i is set when code index i holds a check bit, i.e. i+1 is a power of two.
    function automatic logic [MAX_N-1:0] check_mask(input int n);
        logic [MAX_N-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && ((i + 1) & i) == 0) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [HAM_N-1:0] PARITY_MASK = HAM_N'(check_mask(HAM_N));

endpackage

// File: rtl/ehgu_hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for one codeword.
// Syndrome bit j covers every code index whose 1-based position has bit j set.
module ehgu_hamming_syndrome
    import ehgu_hamming_secded_pkg::*;
#(
    parameter int N = HAM_N,
    parameter int K = HAM_K
)(
    input  logic [N:0]     code,
    output logic [N-K-1:0] syndrome,
    output logic           parity
);

    localparam int S_W = N - K;

    // Fold the Hamming bits into the syndrome and the whole word into the parity.
    always_comb begin
        syndrome = '0;
        for (int j = 0; j < S_W; j++) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) >> j) & 1) == 1) begin
                    syndrome[j] = syndrome[j] ^ code[i];
                end
            end
        end
        parity = ^code;
    end

endmodule

// File: rtl/ehgu_hamming_secded_dec.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshakes.
// S1 registers the Hamming bits with their syndrome and overall parity,
// S2 registers the corrected data and the SEC/DED flags.
// Optional error counters are built when EHGU_SECDED_ERR_CNT_EN is defined.
module ehgu_hamming_secded_dec
    import ehgu_hamming_secded_pkg::*;
#(
    parameter int N     = HAM_N,
    parameter int K     = HAM_K,
    parameter int CNT_W = 16
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N:0]   in_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] out_data,
    output logic         out_sec,
    output logic         out_ded
`ifdef EHGU_SECDED_ERR_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt
`endif
);

    localparam int S_W = N - K;
    localparam logic [N-1:0] CHECK_MASK = N'(check_mask(N));

    // Reject geometries the correction and extraction logic cannot represent.
    if (K < 2 || S_W < 2 || (1 << S_W) < N + 1 || CNT_W < 1) begin : g_param_check
        $error("ehgu_hamming_secded_dec: unsupported N/K/CNT_W combination");
    end

    logic           s1_valid;
    logic [N-1:0]   s1_code;
    logic [S_W-1:0] s1_syn;
    logic           s1_par;

    logic [S_W-1:0] syn_next;
    logic           par_next;

    logic           s1_ready;
    logic           s2_ready;

    err_class_t     err_class;
    logic [N-1:0]   flip_mask;
    logic [N-1:0]   corrected;
    logic [K-1:0]   data_next;

    ehgu_hamming_syndrome #(
        .N (N),
        .K (K)
    ) u_syndrome (
        .code     (in_code),
        .syndrome (syn_next),
        .parity   (par_next)
    );

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // S1: capture the codeword with its syndrome whenever the stage can move.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code[N-1:0];
                s1_syn  <= syn_next;
                s1_par  <= par_next;
            end
        end
    end

    // Classify the error, flip the indicated bit and gather the data bits in order.
    always_comb begin
        err_class = ERR_CLEAN;
        flip_mask = '0;
        if (s1_syn == '0) begin
            err_class = s1_par ? ERR_SEC : ERR_CLEAN;
        end else if (s1_par && int'(s1_syn) <= N) begin
            err_class = ERR_SEC;
            for (int i = 0; i < N; i++) begin
                if (int'(s1_syn) == i + 1) begin
                    flip_mask[i] = 1'b1;
                end
            end
        end else begin
            err_class = ERR_DED;
        end
        corrected = s1_code ^ flip_mask;
        data_next = '0;
        for (int i = 0; i < N; i++) begin
            if (!CHECK_MASK[i]) begin
                data_next = {corrected[i], data_next[K-1:1]};
            end
        end
    end

    // S2: register the result; it is held untouched while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sec   <= 1'b0;
            out_ded   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_next;
                out_sec  <= (err_class == ERR_SEC);
                out_ded  <= (err_class == ERR_DED);
            end
        end
    end

`ifdef EHGU_SECDED_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating event counters bumped on each output handshake; clear has priority.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sec && sec_cnt != CNT_MAX) begin
                sec_cnt <= sec_cnt + CNT_W'(1);
            end
            if (out_ded && ded_cnt != CNT_MAX) begin
                ded_cnt <= ded_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ehgu_hamming_secded_dec.sv
// Self-checking bench for ehgu_hamming_secded_dec (Hamming(7,4)+parity, CNT_W=4).
// Counter checks are compiled only when EHGU_SECDED_ERR_CNT_EN is defined.
module tb_ehgu_hamming_secded_dec;

    localparam int N       = 7;
    localparam int K       = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N:0]   in_code;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_data;
    logic         out_sec;
    logic         out_ded;
`ifdef EHGU_SECDED_ERR_CNT_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] ded_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ehgu_hamming_secded_dec #(
        .N     (N),
        .K     (K),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sec   (out_sec),
        .out_ded   (out_ded)
`ifdef EHGU_SECDED_ERR_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .sec_cnt   (sec_cnt),
        .ded_cnt   (ded_cnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Global safety net so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference encoder: data goes to non-power-of-two positions, check bits make each parity group even.
    function automatic logic [N:0] model_encode(input logic [K-1:0] d);
        logic [N:0] c;
        logic       x;
        int         k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int j = 0; (1 << j) <= N; j++) begin
            x = 1'b0;
            for (int pos = 1; pos <= N; pos++) begin
                if (((pos >> j) & 1) == 1) x = x ^ c[pos-1];
            end
            c[(1 << j) - 1] = x;
        end
        c[N] = ^c[N-1:0];
        return c;
    endfunction

    // Reference data extraction without any correction.
    function automatic logic [K-1:0] model_extract(input logic [N:0] c);
        logic [K-1:0] d;
        int           k;
        d = '0;
        k = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = c[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    // Random codeword with 0, 1 or 2 flipped bits and its expected decode.
    task automatic gen_word(output logic [N:0] code, output logic [K-1:0] exp_data,
                            output logic exp_sec, output logic exp_ded);
        logic [K-1:0] d;
        int nerr, a, b;
        d    = K'($urandom);
        code = model_encode(d);
        nerr = int'($urandom_range(0, 2));
        a    = int'($urandom_range(0, N));
        b    = (a + 1 + int'($urandom_range(0, N - 1))) % (N + 1);
        if (nerr >= 1) code[a] = ~code[a];
        if (nerr == 2) code[b] = ~code[b];
        exp_sec  = (nerr == 1);
        exp_ded  = (nerr == 2);
        exp_data = (nerr == 2) ? model_extract(code) : d;
    endtask

    // Push one codeword through with out_ready high and report what came out and when.
    task automatic run_word(input logic [N:0] code, output logic [K-1:0] data,
                            output logic sec, output logic ded, output int latency);
        int w;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = code;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_code  = '0;
        latency  = 1;
        @(negedge clk);
        while (!out_valid && latency < 20) begin
            @(negedge clk);
            latency++;
        end
        data = out_data;
        sec  = out_sec;
        ded  = out_ded;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_code  = 8'hA7;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++;
        if (out_data !== 4'b0000) begin errors++; $display("[TB] FAIL reset_out_data: got %b required 0000", out_data); end
        checks++;
        if ({out_sec, out_ded} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b required 00", {out_sec, out_ded}); end
`ifdef EHGU_SECDED_ERR_CNT_EN
        checks++;
        if ({sec_cnt, ded_cnt} !== '0) begin errors++; $display("[TB] FAIL reset_counters: got %h/%h required 0/0", sec_cnt, ded_cnt); end
`endif
    endtask

    task automatic test_clean();
        logic [K-1:0] d;
        logic s, e;
        int lat;
        run_word(8'h55, d, s, e, lat);
        checks++;
        if (d !== 4'b1011) begin errors++; $display("[TB] FAIL clean_data: got %b required 1011", d); end
        checks++;
        if ({s, e} !== 2'b00) begin errors++; $display("[TB] FAIL clean_flags: got sec=%b ded=%b required 0 0", s, e); end
        checks++;
        if (lat != 2) begin errors++; $display("[TB] FAIL clean_latency: got %0d required 2", lat); end
`ifdef EHGU_SECDED_ERR_CNT_EN
        checks++;
        if (sec_cnt !== 4'd0) begin errors++; $display("[TB] FAIL clean_sec_cnt: got %0d required 0", sec_cnt); end
`endif
    endtask

    task automatic test_sec_bit4();
        logic [K-1:0] d;
        logic s, e;
        int lat;
        run_word(8'h45, d, s, e, lat);
        checks++;
        if (d !== 4'b1011) begin errors++; $display("[TB] FAIL bit4_data: got %b required 1011", d); end
        checks++;
        if ({s, e} !== 2'b10) begin errors++; $display("[TB] FAIL bit4_flags: got sec=%b ded=%b required 1 0", s, e); end
        checks++;
        if (lat != 2) begin errors++; $display("[TB] FAIL bit4_latency: got %0d required 2", lat); end
`ifdef EHGU_SECDED_ERR_CNT_EN
        checks++;
        if (sec_cnt !== 4'd1) begin errors++; $display("[TB] FAIL bit4_sec_cnt: got %0d required 1", sec_cnt); end
`endif
    endtask

    task automatic test_sec_overall();
        logic [K-1:0] d;
        logic s, e;
        int lat;
        run_word(8'hD5, d, s, e, lat);
        checks++;
        if (d !== 4'b1011) begin errors++; $display("[TB] FAIL overall_data: got %b required 1011", d); end
        checks++;
        if ({s, e} !== 2'b10) begin errors++; $display("[TB] FAIL overall_flags: got sec=%b ded=%b required 1 0", s, e); end
`ifdef EHGU_SECDED_ERR_CNT_EN
        checks++;
        if (sec_cnt !== 4'd2) begin errors++; $display("[TB] FAIL overall_sec_cnt: got %0d required 2", sec_cnt); end
`endif
    endtask

    task automatic test_ded();
        logic [K-1:0] d;
        logic s, e;
        int lat;
        run_word(8'h56, d, s, e, lat);
        checks++;
        if (d !== 4'b1011) begin errors++; $display("[TB] FAIL ded_data: got %b required 1011", d); end
        checks++;
        if ({s, e} !== 2'b01) begin errors++; $display("[TB] FAIL ded_flags: got sec=%b ded=%b required 0 1", s, e); end
`ifdef EHGU_SECDED_ERR_CNT_EN
        checks++;
        if (ded_cnt !== 4'd1) begin errors++; $display("[TB] FAIL ded_ded_cnt: got %0d required 1", ded_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [N:0]   codes[8];
        logic [K+1:0] expq[$];
        logic [K+1:0] hold, exp;
        logic [K-1:0] d;
        logic s, e, held, released;
        int accepted, received, cycles, stall_cycles, w;
        for (int i = 0; i < 8; i++) begin
            gen_word(codes[i], d, s, e);
            expq.push_back({d, s, e});
        end
        accepted = 0; received = 0; cycles = 0; stall_cycles = 0;
        held = 1'b0; released = 1'b0; hold = '0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    in_valid = 1'b1;
                    in_code  = codes[i];
                    w = 0;
                    @(negedge clk);
                    while (!in_ready && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    if (in_ready) accepted++;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                while (received < 8 && cycles < 300) begin
                    @(negedge clk);
                    cycles++;
                    if (!released) begin
                        if (out_valid) begin
                            if (!held) begin
                                held = 1'b1;
                                hold = {out_data, out_sec, out_ded};
                            end else begin
                                checks++;
                                if ({out_data, out_sec, out_ded} !== hold) begin
                                    errors++;
                                    $display("[TB] FAIL b2b_stall_stable: got %b required %b", {out_data, out_sec, out_ded}, hold);
                                end
                            end
                            stall_cycles++;
                            if (stall_cycles == 3) begin
                                checks++;
                                if (accepted != 2) begin errors++; $display("[TB] FAIL b2b_held_words: got %0d required 2", accepted); end
                                checks++;
                                if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_in_ready_stall: got %b required 0", in_ready); end
                                @(posedge clk); #1;
                                out_ready = 1'b1;
                                released  = 1'b1;
                            end
                        end
                    end else if (out_valid) begin
                        exp = expq.pop_front();
                        checks++;
                        if ({out_data, out_sec, out_ded} !== exp) begin
                            errors++;
                            $display("[TB] FAIL b2b_word%0d: got %b required %b", received, {out_data, out_sec, out_ded}, exp);
                        end
                        received++;
                    end
                end
            end
        join
        checks++;
        if (received != 8 || expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d outputs with %0d left required 8 and 0", received, expq.size());
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_duplicate: got out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic seen;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'h45;
        @(posedge clk); #1;
        in_code   = 8'hD5;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_flight: got out_valid=%b required 1", out_valid); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready: got %b required 1", in_ready); end
`ifdef EHGU_SECDED_ERR_CNT_EN
        checks++;
        if ({sec_cnt, ded_cnt} !== '0) begin errors++; $display("[TB] FAIL mid_counters: got %h/%h required 0/0", sec_cnt, ded_cnt); end
`endif
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_discard: got late output=%b required 0", seen); end
    endtask

    task automatic test_random();
        localparam int NUM = 40;
        logic [K+1:0] expq[$];
        logic [K+1:0] exp;
        logic [N:0]   code;
        logic [K-1:0] d;
        logic s, e;
        int received, sec_seen, ded_seen, cycles, w;
        received = 0; sec_seen = 0; ded_seen = 0; cycles = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        fork
            begin
                for (int i = 0; i < NUM; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    gen_word(code, d, s, e);
                    in_valid = 1'b1;
                    in_code  = code;
                    w = 0;
                    @(negedge clk);
                    while (!in_ready && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (in_ready) expq.push_back({d, s, e});
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                while (received < NUM && cycles < 3000) begin
                    @(negedge clk);
                    cycles++;
                    if (out_valid && out_ready) begin
                        checks++;
                        if (expq.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL rand_unexpected: got %b required no output", {out_data, out_sec, out_ded});
                        end else begin
                            exp = expq.pop_front();
                            if (exp[1]) sec_seen++;
                            if (exp[0]) ded_seen++;
                            if ({out_data, out_sec, out_ded} !== exp) begin
                                errors++;
                                $display("[TB] FAIL rand_word%0d: got %b required %b", received, {out_data, out_sec, out_ded}, exp);
                            end
                        end
                        received++;
                    end
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (received != NUM) begin errors++; $display("[TB] FAIL rand_count: got %0d required %0d", received, NUM); end
`ifdef EHGU_SECDED_ERR_CNT_EN
        checks++;
        if (sec_cnt !== CNT_W'((sec_seen > CNT_SAT) ? CNT_SAT : sec_seen)) begin
            errors++;
            $display("[TB] FAIL rand_sec_cnt: got %0d required %0d", sec_cnt, (sec_seen > CNT_SAT) ? CNT_SAT : sec_seen);
        end
        checks++;
        if (ded_cnt !== CNT_W'((ded_seen > CNT_SAT) ? CNT_SAT : ded_seen)) begin
            errors++;
            $display("[TB] FAIL rand_ded_cnt: got %0d required %0d", ded_cnt, (ded_seen > CNT_SAT) ? CNT_SAT : ded_seen);
        end
`endif
    endtask

`ifdef EHGU_SECDED_ERR_CNT_EN
    task automatic test_counter_sat();
        int accepted, w, exp;
        accepted = 0;
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            in_valid = 1'b1;
            in_code  = 8'h45;
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp = (accepted > CNT_SAT) ? CNT_SAT : accepted;
        checks++;
        if (accepted != (1 << CNT_W) + 1) begin errors++; $display("[TB] FAIL sat_accepted: got %0d required %0d", accepted, (1 << CNT_W) + 1); end
        checks++;
        if (sec_cnt !== CNT_W'(exp)) begin errors++; $display("[TB] FAIL sat_sec_cnt: got %0d required %0d", sec_cnt, exp); end
        checks++;
        if (ded_cnt !== 4'd0) begin errors++; $display("[TB] FAIL sat_ded_cnt: got %0d required 0", ded_cnt); end
    endtask

    task automatic test_counter_clear();
        logic [K-1:0] d;
        logic s, e;
        int lat;
        cnt_clr = 1'b1;
        run_word(8'h45, d, s, e, lat);
        cnt_clr = 1'b0;
        checks++;
        if (sec_cnt !== 4'd0) begin errors++; $display("[TB] FAIL clr_priority: got %0d required 0", sec_cnt); end
        run_word(8'h56, d, s, e, lat);
        checks++;
        if ({sec_cnt, ded_cnt} !== {4'd0, 4'd1}) begin
            errors++;
            $display("[TB] FAIL clr_after: got sec=%0d ded=%0d required 0 1", sec_cnt, ded_cnt);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
`ifdef EHGU_SECDED_ERR_CNT_EN
        cnt_clr   = 1'b0;
`endif
        test_reset();
        test_clean();
        test_sec_bit4();
        test_sec_overall();
        test_ded();
        test_back_to_back();
        test_reset_midstream();
        test_random();
`ifdef EHGU_SECDED_ERR_CNT_EN
        test_counter_sat();
        test_counter_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
